// File: rtl/pipeline_hazard_ctrl.sv
// Unified hazard controller: load-use stalls, branch flushes, EX forwarding,
// multi-cycle execute sequencing and saturating stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Rs1_D,
  input  logic [REG_AW-1:0] Rs2_D,
  input  logic              UseRs1_D,
  input  logic              UseRs2_D,
  input  logic [REG_AW-1:0] Rs1_E,
  input  logic [REG_AW-1:0] Rs2_E,
  input  logic [REG_AW-1:0] RD_E,
  input  logic              MemReadE,
  input  logic              McOpE,
  input  logic              PCSrcE,
  input  logic [REG_AW-1:0] RD_M,
  input  logic              RegWriteM,
  input  logic [REG_AW-1:0] RD_W,
  input  logic              RegWriteW,
  input  logic              CntClr,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              BubbleM,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              McBusy,
  output logic              McFirst,
  output logic [CNT_W-1:0]  StallCnt,
  output logic [CNT_W-1:0]  FlushCnt
);

  localparam int MCW = $clog2(MC_LAT) + 1;
  localparam logic [MCW-1:0] MC_LAST = MCW'(MC_LAT - 1);

  logic [MCW-1:0] mcCnt;
  logic           mcStall;
  logic           loadUse;

  assign mcStall = McOpE && (mcCnt != MC_LAST);
  assign McBusy  = (mcCnt != '0);
  assign McFirst = McOpE && (mcCnt == '0);

  // The release cycle wraps the count to 0 so a back-to-back op restarts cleanly.
  always_ff @(posedge clk) begin
    if (rst || !McOpE || (mcCnt == MC_LAST)) mcCnt <= '0;
    else                                     mcCnt <= mcCnt + MCW'(1);
  end

  assign loadUse = MemReadE && (RD_E != '0) &&
                   ((UseRs1_D && (Rs1_D == RD_E)) || (UseRs2_D && (Rs2_D == RD_E)));

  always_comb begin
    StallF  = 1'b0;
    StallD  = 1'b0;
    StallE  = 1'b0;
    FlushD  = 1'b0;
    FlushE  = 1'b0;
    BubbleM = 1'b0;
    if (rst) begin
      StallF = 1'b0;
    end else if (mcStall) begin
      StallF  = 1'b1;
      StallD  = 1'b1;
      StallE  = 1'b1;
      BubbleM = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (loadUse) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  always_comb begin
    ForwardAE = 2'b00;
    if (RegWriteM && (RD_M != '0) && (RD_M == Rs1_E))      ForwardAE = 2'b10;
    else if (RegWriteW && (RD_W != '0) && (RD_W == Rs1_E)) ForwardAE = 2'b01;
  end

  always_comb begin
    ForwardBE = 2'b00;
    if (RegWriteM && (RD_M != '0) && (RD_M == Rs2_E))      ForwardBE = 2'b10;
    else if (RegWriteW && (RD_W != '0) && (RD_W == Rs2_E)) ForwardBE = 2'b01;
  end

  always_ff @(posedge clk) begin
    if (rst || CntClr) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (StallF && (StallCnt != '1)) StallCnt <= StallCnt + CNT_W'(1);
      if (FlushD && (FlushCnt != '1)) FlushCnt <= FlushCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: three DUTs (default, MC_LAT=1, CNT_W=4) share stimulus;
// expectations are queued per cycle and checked by a negedge monitor.
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, UseRs1_D, UseRs2_D, MemReadE, McOpE, PCSrcE, RegWriteM, RegWriteW, CntClr;
  logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W;

  logic aStallF, aStallD, aStallE, aFlushD, aFlushE, aBubbleM, aMcBusy, aMcFirst;
  logic [1:0] aFwdA, aFwdB;
  logic [15:0] aStallCnt, aFlushCnt;
  logic bStallF, bStallD, bStallE, bFlushD, bFlushE, bBubbleM, bMcBusy, bMcFirst;
  logic [1:0] bFwdA, bFwdB;
  logic [15:0] bStallCnt, bFlushCnt;
  logic cStallF, cStallD, cStallE, cFlushD, cFlushE, cBubbleM, cMcBusy, cMcFirst;
  logic [1:0] cFwdA, cFwdB;
  logic [3:0] cStallCnt, cFlushCnt;

  pipeline_hazard_ctrl #(.REG_AW(5), .MC_LAT(4), .CNT_W(16)) dutA (
    .clk(clk), .rst(rst), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .UseRs1_D(UseRs1_D), .UseRs2_D(UseRs2_D),
    .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .RD_E(RD_E), .MemReadE(MemReadE), .McOpE(McOpE), .PCSrcE(PCSrcE),
    .RD_M(RD_M), .RegWriteM(RegWriteM), .RD_W(RD_W), .RegWriteW(RegWriteW), .CntClr(CntClr),
    .StallF(aStallF), .StallD(aStallD), .StallE(aStallE), .FlushD(aFlushD), .FlushE(aFlushE),
    .BubbleM(aBubbleM), .ForwardAE(aFwdA), .ForwardBE(aFwdB), .McBusy(aMcBusy), .McFirst(aMcFirst),
    .StallCnt(aStallCnt), .FlushCnt(aFlushCnt));

  pipeline_hazard_ctrl #(.REG_AW(5), .MC_LAT(1), .CNT_W(16)) dutB (
    .clk(clk), .rst(rst), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .UseRs1_D(UseRs1_D), .UseRs2_D(UseRs2_D),
    .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .RD_E(RD_E), .MemReadE(MemReadE), .McOpE(McOpE), .PCSrcE(PCSrcE),
    .RD_M(RD_M), .RegWriteM(RegWriteM), .RD_W(RD_W), .RegWriteW(RegWriteW), .CntClr(CntClr),
    .StallF(bStallF), .StallD(bStallD), .StallE(bStallE), .FlushD(bFlushD), .FlushE(bFlushE),
    .BubbleM(bBubbleM), .ForwardAE(bFwdA), .ForwardBE(bFwdB), .McBusy(bMcBusy), .McFirst(bMcFirst),
    .StallCnt(bStallCnt), .FlushCnt(bFlushCnt));

  pipeline_hazard_ctrl #(.REG_AW(5), .MC_LAT(4), .CNT_W(4)) dutC (
    .clk(clk), .rst(rst), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .UseRs1_D(UseRs1_D), .UseRs2_D(UseRs2_D),
    .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .RD_E(RD_E), .MemReadE(MemReadE), .McOpE(McOpE), .PCSrcE(PCSrcE),
    .RD_M(RD_M), .RegWriteM(RegWriteM), .RD_W(RD_W), .RegWriteW(RegWriteW), .CntClr(CntClr),
    .StallF(cStallF), .StallD(cStallD), .StallE(cStallE), .FlushD(cFlushD), .FlushE(cFlushE),
    .BubbleM(cBubbleM), .ForwardAE(cFwdA), .ForwardBE(cFwdB), .McBusy(cMcBusy), .McFirst(cMcFirst),
    .StallCnt(cStallCnt), .FlushCnt(cFlushCnt));

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int checks = 0;
  int passes = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      0:  obs = 32'(aStallF);
      1:  obs = 32'(aStallD);
      2:  obs = 32'(aStallE);
      3:  obs = 32'(aFlushD);
      4:  obs = 32'(aFlushE);
      5:  obs = 32'(aBubbleM);
      6:  obs = 32'(aFwdA);
      7:  obs = 32'(aFwdB);
      8:  obs = 32'(aMcBusy);
      9:  obs = 32'(aMcFirst);
      10: obs = 32'(aStallCnt);
      11: obs = 32'(aFlushCnt);
      20: obs = 32'(bStallF);
      23: obs = 32'(bFlushD);
      28: obs = 32'(bMcBusy);
      29: obs = 32'(bMcFirst);
      30: obs = 32'(bStallCnt);
      31: obs = 32'(bFlushCnt);
      40: obs = 32'(cStallCnt);
      default: obs = 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: every negedge, compare all expectations tagged for the current cycle.
  always @(negedge clk) begin
    while (q.size() != 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [31:0] act;
      e = q.pop_front();
      act = obs(e.sel);
      checks++;
      if (e.cyc != cyc)
        $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", e.name, e.cyc, cyc);
      else if (act !== e.exp)
        $display("FAIL %s: cycle %0d actual %0h required %0h", e.name, cyc, act, e.exp);
      else
        passes++;
    end
  end

  task automatic ex(input string n, input int sel, input logic [31:0] v);
    exp_t e;
    e.cyc = cyc; e.sel = sel; e.exp = v; e.name = n;
    q.push_back(e);
  endtask

  task automatic nextCyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clrIn();
    rst = 0; UseRs1_D = 0; UseRs2_D = 0; MemReadE = 0; McOpE = 0; PCSrcE = 0;
    RegWriteM = 0; RegWriteW = 0; CntClr = 0;
    Rs1_D = 0; Rs2_D = 0; Rs1_E = 0; Rs2_E = 0; RD_E = 0; RD_M = 0; RD_W = 0;
  endtask

  task automatic setLu(input logic use2);
    MemReadE = 1; RD_E = 7; Rs2_D = 7; UseRs2_D = use2;
  endtask

  initial begin
    clrIn();
    rst = 1;
    nextCyc();
    rst = 1; PCSrcE = 1; McOpE = 1;
    ex("rst_stallcnt", 10, 0); ex("rst_flushcnt", 11, 0); ex("rst_mcbusy", 8, 0);
    ex("rst_flushd", 3, 0); ex("rst_stallf", 0, 0); ex("rst_flushe", 4, 0);
    nextCyc();

    // Forwarding
    clrIn();
    RegWriteM = 1; RD_M = 5; RegWriteW = 1; RD_W = 5; Rs1_E = 5; Rs2_E = 3;
    ex("fwdA_mem", 6, 2); ex("fwdB_none", 7, 0);
    nextCyc();
    RD_M = 0;
    ex("fwdA_wb", 6, 1);
    nextCyc();
    Rs1_E = 0; Rs2_E = 5; RegWriteM = 1; RD_M = 0;
    ex("fwdA_x0", 6, 0); ex("fwdB_wb", 7, 1);
    nextCyc();
    RD_M = 9; Rs2_E = 9;
    ex("fwdB_mem", 7, 2);
    nextCyc();

    // Load-use
    clrIn(); setLu(1);
    ex("lu_stallf", 0, 1); ex("lu_stalld", 1, 1); ex("lu_flushe", 4, 1);
    ex("lu_stalle", 2, 0); ex("lu_flushd", 3, 0);
    nextCyc();
    clrIn(); setLu(0);
    ex("lu_cnt1", 10, 1); ex("nolu_stallf", 0, 0);
    nextCyc();
    clrIn(); MemReadE = 1; RD_E = 0; Rs1_D = 0; UseRs1_D = 1;
    ex("lu_x0_stallf", 0, 0); ex("nolu_cnt", 10, 1);
    nextCyc();

    // Branch overrides load-use
    clrIn(); setLu(1); PCSrcE = 1;
    ex("br_flushd", 3, 1); ex("br_flushe", 4, 1); ex("br_stallf", 0, 0); ex("br_stalld", 1, 0);
    nextCyc();
    clrIn();
    ex("br_flushcnt", 11, 1); ex("br_stallcnt", 10, 1);
    nextCyc();

    // Multi-cycle op, MC_LAT=4 on A and MC_LAT=1 on B
    clrIn(); McOpE = 1; RegWriteM = 1; RD_M = 4; Rs1_E = 4;
    ex("mc1_stallf", 0, 1); ex("mc1_stalle", 2, 1); ex("mc1_bubm", 5, 1);
    ex("mc1_first", 9, 1); ex("mc1_busy", 8, 0); ex("mc1_fwd", 6, 2);
    ex("b_mc1_stallf", 20, 0); ex("b_mc1_first", 29, 1);
    nextCyc();
    PCSrcE = 1;
    ex("mc2_stalld", 1, 1); ex("mc2_first", 9, 0); ex("mc2_busy", 8, 1); ex("mc2_flushd", 3, 0);
    ex("b_mc2_flushd", 23, 1); ex("b_mc2_first", 29, 1); ex("b_mc2_busy", 28, 0);
    nextCyc();
    PCSrcE = 0;
    ex("mc3_stallf", 0, 1); ex("mc3_busy", 8, 1); ex("b_mc3_stallf", 20, 0);
    nextCyc();
    ex("mc4_stallf", 0, 0); ex("mc4_stalle", 2, 0); ex("mc4_bubm", 5, 0);
    ex("mc4_busy", 8, 1); ex("mc4_first", 9, 0);
    nextCyc();
    clrIn();
    ex("mc_done_busy", 8, 0); ex("mc_stallcnt", 10, 4); ex("mc_flushcnt", 11, 1);
    ex("b_stallcnt", 30, 1); ex("b_flushcnt", 31, 2);
    nextCyc();

    // Reset in the middle of a multi-cycle sequence
    McOpE = 1; nextCyc();
    nextCyc();
    rst = 1;
    ex("rstmc_stallf", 0, 0); ex("rstmc_stalle", 2, 0); ex("rstmc_bubm", 5, 0); ex("rstmc_busy", 8, 1);
    nextCyc();
    rst = 0;
    ex("rstmc_first", 9, 1); ex("rstmc_restall", 0, 1); ex("rstmc_cnt0", 10, 0);
    nextCyc();
    nextCyc();
    nextCyc();
    ex("rstmc_release", 0, 0);
    nextCyc();
    clrIn();
    ex("rstmc_stallcnt", 10, 3);
    nextCyc();

    // Saturation on the 4-bit counters of C
    clrIn(); setLu(1);
    repeat (20) nextCyc();
    CntClr = 1;
    ex("sat_c", 40, 15); ex("sat_a", 10, 23);
    nextCyc();
    CntClr = 0;
    ex("clr_c", 40, 0); ex("clr_a", 10, 0);
    nextCyc();
    ex("after_clr_c", 40, 1);
    nextCyc();
    clrIn();

    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    #2;
    if (q.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Unified hazard controller for the 5-stage RISC-V pipeline. It merges load-use detection, branch flushing and EX-operand forwarding in one block.
- It adds stall sequencing for a parametrised multi-cycle execute unit (MUL/DIV) and saturating performance counters.
- It sits beside the stage modules at the pipeline top and drives the stall, flush and forward selects for the Fetch, Decode and Execute stage registers.

Parameters:
- REG_AW, 5, register-address width.
- MC_LAT, 4, total cycles a multi-cycle op occupies EX; legal range 1..16. MC_LAT=1 means no stall.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- Rs1_D  in  REG_AW  rs1 of the instruction in ID
- Rs2_D  in  REG_AW  rs2 of the instruction in ID
- UseRs1_D  in  1  the ID instruction reads rs1
- UseRs2_D  in  1  the ID instruction reads rs2
- Rs1_E  in  REG_AW  rs1 of the instruction in EX
- Rs2_E  in  REG_AW  rs2 of the instruction in EX
- RD_E  in  REG_AW  destination register of the instruction in EX
- MemReadE  in  1  the EX instruction is a load
- McOpE  in  1  the EX instruction is a multi-cycle op
- PCSrcE  in  1  branch/jump taken in EX
- RD_M  in  REG_AW  destination register in MEM
- RegWriteM  in  1  MEM instruction writes the register file
- RD_W  in  REG_AW  destination register in WB
- RegWriteW  in  1  WB instruction writes the register file
- CntClr  in  1  synchronous clear of the performance counters
- StallF  out  1  hold PC
- StallD  out  1  hold the IF/ID register
- StallE  out  1  hold the ID/EX register
- FlushD  out  1  zero the IF/ID register
- FlushE  out  1  insert a bubble into ID/EX
- BubbleM  out  1  insert a bubble into EX/MEM
- ForwardAE  out  2  operand A select: 00 register file, 01 WB, 10 MEM
- ForwardBE  out  2  operand B select, same encoding
- McBusy  out  1  multi-cycle sequence in progress (mc_cnt != 0)
- McFirst  out  1  first EX cycle of a multi-cycle op; the MC unit captures its operands here
- StallCnt  out  CNT_W  cycles with StallF=1
- FlushCnt  out  CNT_W  cycles with FlushD=1

Behaviour:
- Internal state: `mc_cnt`, width clog2(MC_LAT)+1, reset to 0.
  - mc_stall = McOpE && (mc_cnt != MC_LAT-1).
  - On each edge while McOpE: if mc_cnt == MC_LAT-1, mc_cnt returns to 0 (release cycle, the op advances); otherwise mc_cnt increments.
  - When McOpE=0, mc_cnt is forced to 0.
  - Result: the op stays in EX for exactly MC_LAT cycles, with MC_LAT-1 stall cycles.
  - McFirst = McOpE && mc_cnt==0.
  - Back-to-back MC ops: the second op enters EX with mc_cnt=0 and gets a full sequence.
- Load-use hazard, lu = MemReadE && RD_E != 0 && ((UseRs1_D && Rs1_D == RD_E) || (UseRs2_D && Rs2_D == RD_E)).
- Output priority, all outputs combinational:
  1. rst=1: every stall/flush/bubble output is 0.
  2. mc_stall: StallF = StallD = StallE = BubbleM = 1; FlushD = FlushE = 0. PCSrcE and lu are ignored, because an MC op in EX is never a branch or a load.
  3. PCSrcE: FlushD = FlushE = 1; all stalls 0. This overrides lu, since the dependent instruction is squashed.
  4. lu: StallF = StallD = 1, FlushE = 1; StallE = 0.
  5. Otherwise: all outputs 0.
- Forwarding, evaluated independently for A (Rs1_E) and B (Rs2_E):
  - 10 if RegWriteM && RD_M != 0 && RD_M == Rs_E;
  - else 01 if RegWriteW && RD_W != 0 && RD_W == Rs_E;
  - else 00.
  - MEM has priority over WB. x0 is never forwarded. Forwarding stays active during an MC stall.
- Counters:
  - Update on clk edge; reset and CntClr set them to 0. CntClr has priority over increment.
  - StallCnt increments when StallF=1.
  - FlushCnt increments when FlushD=1.
  - Both saturate at 2^CNT_W-1 and do not wrap.
- Reset mid-sequence: mc_cnt returns to 0 on the next edge; counters clear.

Test Plan:
- Forwarding. `add x5` in MEM (RegWriteM=1, RD_M=5), `sub x5` in WB, Rs1_E=5 -> ForwardAE=10. Repeat with RD_M=0 and RD_W=5 -> ForwardAE=01. With Rs1_E=0 and RD_M=0, RegWriteM=1 -> 00.
- Load-use. MemReadE=1, RD_E=7, Rs2_D=7, UseRs2_D=1 -> one cycle of StallF=StallD=FlushE=1, StallCnt=1. Same with UseRs2_D=0 -> no stall.
- Branch vs load-use. PCSrcE=1 and lu both true -> FlushD=FlushE=1, StallF=0, FlushCnt increments by 1.
- Multi-cycle, MC_LAT=4. McOpE held 4 cycles -> StallF/StallD/StallE/BubbleM=1 for cycles 1-3 and 0 on cycle 4; McFirst only on cycle 1; McBusy=1 on cycles 2-4; StallCnt=3. Also run MC_LAT=1 -> no stall at all.
- Reset during an MC sequence. rst=1 at mc_cnt=2 -> outputs 0 that cycle; after rst drops, with McOpE=1 the sequence restarts from McFirst=1.
- Saturation. CNT_W=4, stall 20 cycles -> StallCnt=15. Then CntClr=1 together with a stall -> StallCnt=0.
